// File: rtl/core_mem_arbiter.sv
// Arbitrates one external memory port between instruction fetch and the data stage; D has fixed priority.
// Latency: grant on the request edge, M_REQ the cycle after, DONE the cycle after M_ACK (best case 2 cycles).
// Backpressure: requesters hold REQ until DONE; the bus stalls via M_ACK and a timeout bounds the wait.
module core_mem_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              RST,
   // instruction fetch side
   input  logic              I_REQ,
   input  logic [AW-1:0]     I_ADDR,
   input  logic              I_FLUSH,
   output logic [DW-1:0]     I_RDATA,
   output logic              HCU_IMEM_DONE,
   output logic              HCU_IMEM_BUSY,
   // data stage side
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [AW-1:0]     D_ADDR,
   input  logic [DW-1:0]     D_WDATA,
   input  logic [DW/8-1:0]   D_WSTRB,
   output logic [DW-1:0]     D_RDATA,
   output logic              D_DONE,
   output logic              HCU_DMEM_BUSY,
   // external memory bus
   output logic              M_REQ,
   output logic              M_WE,
   output logic [AW-1:0]     M_ADDR,
   output logic [DW-1:0]     M_WDATA,
   output logic [DW/8-1:0]   M_WSTRB,
   input  logic [DW-1:0]     M_RDATA,
   input  logic              M_ACK,
   output logic              ERR_TIMEOUT
);

   localparam int SW     = DW / 8;
   localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;
   // Counter value seen during the last permitted M_REQ cycle.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } state_t;

   state_t          state_q;
   logic            m_req_q;
   logic            m_we_q;
   logic [AW-1:0]   m_addr_q;
   logic [DW-1:0]   m_wdata_q;
   logic [SW-1:0]   m_wstrb_q;
   logic [DW-1:0]   i_rdata_q;
   logic [DW-1:0]   d_rdata_q;
   logic            i_done_q;
   logic            d_done_q;
   logic            err_q;
   logic            drop_q;
   logic [CW-1:0]   cnt_q;

   // Access finishes on ack, or on timeout when no ack arrives (ack wins a tie).
   logic            acc_end;
   logic            fetch_cancelled;
   assign acc_end         = M_ACK || (cnt_q == CNT_LAST);
   assign fetch_cancelled = drop_q || I_FLUSH;

   // Arbitration, bus sequencing, completion pulses and timeout tracking.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         drop_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               // A requester whose DONE is showing this cycle is not re-granted yet.
               if (D_REQ && !d_done_q) begin
                  state_q   <= D_ACC;
                  m_req_q   <= 1'b1;
                  m_we_q    <= D_WE;
                  m_addr_q  <= D_ADDR;
                  m_wdata_q <= D_WDATA;
                  m_wstrb_q <= D_WE ? D_WSTRB : '0;
                  cnt_q     <= '0;
               end else if (I_REQ && !I_FLUSH && !i_done_q) begin
                  state_q   <= I_ACC;
                  m_req_q   <= 1'b1;
                  m_we_q    <= 1'b0;
                  m_addr_q  <= I_ADDR;
                  m_wdata_q <= '0;
                  m_wstrb_q <= '0;
                  cnt_q     <= '0;
               end
            end
            I_ACC, D_ACC: begin
               // A flushed fetch still runs to completion on the bus; only its result is discarded.
               if (state_q == I_ACC && I_FLUSH) begin
                  drop_q <= 1'b1;
               end
               if (acc_end) begin
                  state_q <= IDLE;
                  m_req_q <= 1'b0;
                  if (!M_ACK) begin
                     err_q <= 1'b1;
                  end
                  if (state_q == D_ACC) begin
                     d_done_q  <= 1'b1;
                     d_rdata_q <= (M_ACK && !m_we_q) ? M_RDATA : '0;
                  end else if (!fetch_cancelled) begin
                     i_done_q  <= 1'b1;
                     i_rdata_q <= M_ACK ? M_RDATA : '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               m_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign M_REQ         = m_req_q;
   assign M_WE          = m_we_q;
   assign M_ADDR        = m_addr_q;
   assign M_WDATA       = m_wdata_q;
   assign M_WSTRB       = m_wstrb_q;
   assign I_RDATA       = i_rdata_q;
   assign D_RDATA       = d_rdata_q;
   assign HCU_IMEM_DONE = i_done_q;
   assign D_DONE        = d_done_q;
   assign ERR_TIMEOUT   = err_q;
   assign HCU_IMEM_BUSY = I_REQ & ~i_done_q;
   assign HCU_DMEM_BUSY = D_REQ & ~d_done_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model predicts every output; outputs are compared on each falling edge.
// Requesters and the bus slave are driven from the bench and obey the hold-until-DONE handshake.
module tb_core_mem_arbiter;

   localparam int TO = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          I_REQ, I_FLUSH, D_REQ, D_WE, M_ACK;
   logic [31:0]   I_ADDR, D_ADDR, D_WDATA, M_RDATA;
   logic [3:0]    D_WSTRB;
   logic [31:0]   I_RDATA, D_RDATA, M_ADDR, M_WDATA;
   logic [3:0]    M_WSTRB;
   logic          HCU_IMEM_DONE, HCU_IMEM_BUSY, D_DONE, HCU_DMEM_BUSY;
   logic          M_REQ, M_WE, ERR_TIMEOUT;

   int            n_checks = 0;
   int            n_errors = 0;

   core_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_FLUSH(I_FLUSH), .I_RDATA(I_RDATA),
      .HCU_IMEM_DONE(HCU_IMEM_DONE), .HCU_IMEM_BUSY(HCU_IMEM_BUSY),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
      .D_RDATA(D_RDATA), .D_DONE(D_DONE), .HCU_DMEM_BUSY(HCU_DMEM_BUSY),
      .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
      .M_RDATA(M_RDATA), .M_ACK(M_ACK), .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   // Transaction-level model: who owns the bus, how long it has waited, whether the fetch is void.
   int            mo_owner;   // 0 none, 1 fetch, 2 data
   int            mo_wait;
   bit            mo_drop;
   bit            e_mreq, e_mwe, e_idone, e_ddone, e_err;
   logic [31:0]   e_maddr, e_mwdata, e_irdata, e_drdata;
   logic [3:0]    e_mstrb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mo_owner = 0; mo_wait = 0; mo_drop = 0;
      e_mreq = 0; e_mwe = 0; e_idone = 0; e_ddone = 0; e_err = 0;
      e_maddr = 0; e_mwdata = 0; e_irdata = 0; e_drdata = 0; e_mstrb = 0;
   endtask

   task automatic model_edge();
      bit          was_idone, was_ddone, finished;
      logic [31:0] data;
      was_idone = e_idone;
      was_ddone = e_ddone;
      e_idone = 0;
      e_ddone = 0;
      finished = 0;
      data = 0;
      if (mo_owner == 0) begin
         mo_drop = 0;
         if (D_REQ && !was_ddone) begin
            mo_owner = 2; mo_wait = 0; e_mreq = 1;
            e_mwe = D_WE; e_maddr = D_ADDR; e_mwdata = D_WDATA;
            e_mstrb = D_WE ? D_WSTRB : 4'h0;
         end else if (I_REQ && !I_FLUSH && !was_idone) begin
            mo_owner = 1; mo_wait = 0; e_mreq = 1;
            e_mwe = 0; e_maddr = I_ADDR; e_mwdata = 0; e_mstrb = 0;
         end
      end else begin
         mo_wait++;
         if (mo_owner == 1 && I_FLUSH) mo_drop = 1;
         if (M_ACK) begin
            finished = 1;
            data = e_mwe ? 32'h0 : M_RDATA;
         end else if (mo_wait >= TO) begin
            finished = 1;
            data = 32'h0;
            e_err = 1;
         end
         if (finished) begin
            if (mo_owner == 2) begin
               e_ddone = 1; e_drdata = data;
            end else if (!mo_drop) begin
               e_idone = 1; e_irdata = data;
            end
            mo_owner = 0;
            e_mreq = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("m_req",     32'(M_REQ),         32'(e_mreq));
      chk("m_we",      32'(M_WE),          32'(e_mwe));
      chk("m_addr",    M_ADDR,             e_maddr);
      chk("m_wdata",   M_WDATA,            e_mwdata);
      chk("m_wstrb",   32'(M_WSTRB),       32'(e_mstrb));
      chk("i_done",    32'(HCU_IMEM_DONE), 32'(e_idone));
      chk("i_rdata",   I_RDATA,            e_irdata);
      chk("d_done",    32'(D_DONE),        32'(e_ddone));
      chk("d_rdata",   D_RDATA,            e_drdata);
      chk("err",       32'(ERR_TIMEOUT),   32'(e_err));
      chk("i_busy",    32'(HCU_IMEM_BUSY), 32'(I_REQ & ~e_idone));
      chk("d_busy",    32'(HCU_DMEM_BUSY), 32'(D_REQ & ~e_ddone));
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare_all();
   endtask

   bit last_flush = 0;

   task automatic drive_random();
      // fetch master
      if (I_REQ && (e_idone || last_flush)) begin
         I_REQ = $urandom_range(0, 1) == 1;
         I_ADDR = $urandom() & 32'hFFFF_FFFC;
      end else if (!I_REQ) begin
         I_REQ = $urandom_range(0, 2) == 0;
         I_ADDR = $urandom() & 32'hFFFF_FFFC;
      end
      last_flush = I_FLUSH;
      I_FLUSH = $urandom_range(0, 7) == 0;
      // data master
      if ((D_REQ && e_ddone) || !D_REQ) begin
         D_REQ = $urandom_range(0, 3) == 0;
         D_WE = $urandom_range(0, 1) == 1;
         D_ADDR = $urandom();
         D_WDATA = $urandom();
         D_WSTRB = 4'($urandom_range(0, 15));
      end
      // bus slave, with occasional stray acks while idle
      M_RDATA = $urandom();
      M_ACK = e_mreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      int n;
      RST = 1; I_REQ = 0; I_FLUSH = 0; I_ADDR = 0;
      D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0; D_WSTRB = 0;
      M_ACK = 0; M_RDATA = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      compare_all();
      chk("rst_m_req", 32'(M_REQ), 32'd0);
      chk("rst_err",   32'(ERR_TIMEOUT), 32'd0);
      chk("rst_irdata", I_RDATA, 32'd0);
      RST = 0;

      // 1: fetch, ack on the 4th M_REQ cycle (ties with the timeout, ack wins)
      I_REQ = 1; I_ADDR = 32'h100;
      step();
      chk("t1_m_req", 32'(M_REQ), 32'd1);
      chk("t1_m_addr", M_ADDR, 32'h100);
      repeat (3) begin
         step();
         chk("t1_busy_wait", 32'(HCU_IMEM_BUSY), 32'd1);
      end
      M_ACK = 1; M_RDATA = 32'h0000_0013;
      step();
      chk("t1_idone", 32'(HCU_IMEM_DONE), 32'd1);
      chk("t1_irdata", I_RDATA, 32'h13);
      chk("t1_busy_done", 32'(HCU_IMEM_BUSY), 32'd0);
      chk("t1_no_err", 32'(ERR_TIMEOUT), 32'd0);
      M_ACK = 0; I_REQ = 0;
      step();
      chk("t1_idone_pulse", 32'(HCU_IMEM_DONE), 32'd0);

      // 2: simultaneous requests, data store wins
      I_REQ = 1; I_ADDR = 32'h104;
      D_REQ = 1; D_WE = 1; D_ADDR = 32'h200; D_WDATA = 32'hDEAD_BEEF; D_WSTRB = 4'hF;
      step();
      chk("t2_m_we", 32'(M_WE), 32'd1);
      chk("t2_m_addr", M_ADDR, 32'h200);
      chk("t2_m_wdata", M_WDATA, 32'hDEAD_BEEF);
      chk("t2_m_wstrb", 32'(M_WSTRB), 32'hF);
      M_ACK = 1; M_RDATA = 32'h5555_5555;
      step();
      chk("t2_ddone", 32'(D_DONE), 32'd1);
      chk("t2_drdata", D_RDATA, 32'd0);
      chk("t2_idle_gap", 32'(M_REQ), 32'd0);
      M_ACK = 0; D_REQ = 0;
      step();
      chk("t2_i_grant", 32'(M_REQ), 32'd1);
      chk("t2_i_addr", M_ADDR, 32'h104);
      chk("t2_i_we", 32'(M_WE), 32'd0);
      M_ACK = 1; M_RDATA = 32'h0000_0093;
      step();
      chk("t2_idone", 32'(HCU_IMEM_DONE), 32'd1);
      chk("t2_irdata", I_RDATA, 32'h93);
      M_ACK = 0; I_REQ = 0;
      step();

      // 3: flushed fetch completes on the bus but is discarded
      I_REQ = 1; I_ADDR = 32'h200;
      step();
      I_FLUSH = 1;
      step();
      chk("t3_mreq_held", 32'(M_REQ), 32'd1);
      I_FLUSH = 0; I_REQ = 0;
      step();
      M_ACK = 1; M_RDATA = 32'hBAD0_BAD0;
      step();
      chk("t3_no_idone", 32'(HCU_IMEM_DONE), 32'd0);
      chk("t3_irdata_kept", I_RDATA, 32'h93);
      M_ACK = 0; I_REQ = 1; I_ADDR = 32'h300;
      step();
      chk("t3_regrant", M_ADDR, 32'h300);
      M_ACK = 1; M_RDATA = 32'h0000_0513;
      step();
      chk("t3_irdata", I_RDATA, 32'h513);
      M_ACK = 0; I_REQ = 0;
      // load, so D_RDATA is nonzero before the timeout
      D_REQ = 1; D_WE = 0; D_ADDR = 32'h500; D_WSTRB = 4'hF;
      step();
      chk("ld_wstrb_zero", 32'(M_WSTRB), 32'd0);
      M_ACK = 1; M_RDATA = 32'hCAFE_F00D;
      step();
      chk("ld_drdata", D_RDATA, 32'hCAFE_F00D);
      M_ACK = 0; D_REQ = 0;
      step();

      // 4: load that never gets acked
      D_REQ = 1; D_WE = 0; D_ADDR = 32'h600;
      step();
      n = 0;
      while (M_REQ && n < 12) begin
         n++;
         step();
      end
      chk("t4_mreq_cycles", 32'(n), 32'd4);
      chk("t4_ddone", 32'(D_DONE), 32'd1);
      chk("t4_drdata", D_RDATA, 32'd0);
      chk("t4_err", 32'(ERR_TIMEOUT), 32'd1);
      D_REQ = 0;
      step();
      chk("t4_err_sticky", 32'(ERR_TIMEOUT), 32'd1);

      // 5: reset in the middle of an access, then a late ack
      D_REQ = 1; D_WE = 1; D_ADDR = 32'h700; D_WDATA = 32'h1234_5678; D_WSTRB = 4'h3;
      step();
      chk("t5_mreq_before", 32'(M_REQ), 32'd1);
      #2 RST = 1;
      #1;
      chk("t5_mreq_rst", 32'(M_REQ), 32'd0);
      chk("t5_ddone_rst", 32'(D_DONE), 32'd0);
      chk("t5_err_rst", 32'(ERR_TIMEOUT), 32'd0);
      model_reset();
      D_REQ = 0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 0;
      compare_all();
      M_ACK = 1;
      step();
      chk("t5_late_ack_mreq", 32'(M_REQ), 32'd0);
      chk("t5_late_ack_done", 32'(D_DONE), 32'd0);
      M_ACK = 0;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         drive_random();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
